// File: rtl/rng_share_pkg.sv
// Shared types and helpers for the RNG sharing controller and its arbiter.
package rng_share_pkg;

  localparam int RNG_W          = 32;
  localparam int RESEED_LAT_DEF = 2;
  localparam int MAX_REQ        = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // One-hot vector for a requester index, sized for the widest supported requester set.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rng_share_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin pick among an eligible mask. The search starts at the
// stored pointer, and after an accepted grant the pointer moves to winner+1.
// Reusable by any block that shares a single producer between N consumers.
module rr_arbiter
  import rng_share_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_eligible,
  input  logic         i_en,
  output logic         o_valid,
  output logic [N-1:0] o_onehot
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_j;
  logic          w_found;

  // Scan eligible requesters starting from the pointer, wrapping at N.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = PW'((int'(r_ptr) + k) % N);
      if (!w_found && i_eligible[w_j]) begin
        w_found = 1'b1;
        w_idx   = w_j;
      end
    end
  end

  // Advance the pointer past the winner only when the grant is actually taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
    end
  end

  assign o_valid  = w_found;
  assign o_onehot = w_found ? N'(onehot(4'(w_idx))) : '0;

endmodule

// File: rtl/rng_share_ctrl.sv
// rng_share_ctrl: shares one free-running 32-bit generator between N_REQ
// requesters (each word to at most one requester) and sequences reseeds:
// a one-cycle seed pulse, then a flush of words still produced from the old seed.
// Optional per-requester grant statistics: define RNG_SHARE_CTRL_STATS_EN.
//
//   state | meaning
//   RUN   | normal arbitration; a pending reseed request is accepted here
//   ISSUE | drive rng_re_seed with the latched seed for one cycle
//   FLUSH | discard stale generator words for RESEED_LAT cycles, then ack
module rng_share_ctrl
  import rng_share_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int RESEED_LAT = RESEED_LAT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  output logic [N_REQ-1:0]       gnt,
  output logic [RNG_W-1:0]       rnd_out,
  input  logic                   reseed_req,
  input  logic [RNG_W-1:0]       reseed_seed,
  output logic                   reseed_ack,
  output logic                   busy,
  output logic [RNG_W-1:0]       rng_seed,
  output logic                   rng_re_seed,
  input  logic [RNG_W-1:0]       rng_rnd
`ifdef RNG_SHARE_CTRL_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0] grant_cnt
`endif
);

  localparam int CW = (RESEED_LAT > 1) ? $clog2(RESEED_LAT) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [RNG_W-1:0] r_rnd;
  logic             r_ack;
  logic [RNG_W-1:0] r_seed;
  logic [CW-1:0]    r_flush_cnt;

  logic             w_accept;
  logic             w_grant_en;
  logic             w_done;
  logic             w_re_seed;
  logic             w_arb_valid;
  logic [N_REQ-1:0] w_arb_oh;
  logic [N_REQ-1:0] w_eligible;
  logic             w_take;

  // The requester shown a grant this cycle is masked so its falling req
  // cannot win a second word.
  assign w_eligible = req & ~r_gnt;
  assign w_take     = w_grant_en & w_arb_valid;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_eligible (w_eligible),
    .i_en       (w_grant_en),
    .o_valid    (w_arb_valid),
    .o_onehot   (w_arb_oh)
  );

  // Next state and per-state strobes; reseed takes priority over grants in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_grant_en  = 1'b0;
    w_done      = 1'b0;
    w_re_seed   = 1'b0;
    case (r_state)
      RUN: begin
        if (reseed_req) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_grant_en = 1'b1;
        end
      end
      ISSUE: begin
        w_re_seed   = 1'b1;
        w_state_nxt = FLUSH;
      end
      FLUSH: begin
        if (r_flush_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State register, registered grant/word outputs, seed latch and flush timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_gnt       <= '0;
      r_rnd       <= '0;
      r_ack       <= 1'b0;
      r_seed      <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_done;
      r_gnt   <= w_take ? w_arb_oh : '0;
      if (w_take) begin
        r_rnd <= rng_rnd;
      end
      if (w_accept) begin
        r_seed <= reseed_seed;
      end
      if (w_re_seed) begin
        r_flush_cnt <= CW'(RESEED_LAT - 1);
      end else if ((r_state == FLUSH) && (r_flush_cnt != '0)) begin
        r_flush_cnt <= r_flush_cnt - CW'(1);
      end
    end
  end

  assign gnt         = r_gnt;
  assign rnd_out     = r_rnd;
  assign reseed_ack  = r_ack;
  assign busy        = (r_state != RUN);
  assign rng_seed    = r_seed;
  assign rng_re_seed = w_re_seed;

`ifdef RNG_SHARE_CTRL_STATS_EN
  logic [CNT_W-1:0] r_cnt [N_REQ];

  // Saturating grant counters; cleared at each reseed completion so they cover one seed epoch.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      if (rst || w_done) begin
        r_cnt[i] <= '0;
      end else if (r_gnt[i] && (r_cnt[i] != '1)) begin
        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Flatten the counters onto the output bus, requester 0 in the low bits.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_rng_share_ctrl.sv
// Bench for rng_share_ctrl. The generator is a stub: a counter that loads the
// seed on rng_re_seed, seen through RESEED_LAT output registers, so the first
// post-reseed word equals the seed and words step by one per cycle.
module tb_rng_share_ctrl;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [31:0]  rnd_out;
  logic         reseed_req;
  logic [31:0]  reseed_seed;
  logic         reseed_ack;
  logic         busy;
  logic [31:0]  rng_seed;
  logic         rng_re_seed;
  logic [31:0]  rng_rnd;
`ifdef RNG_SHARE_CTRL_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rng_share_ctrl #(.N_REQ(N), .RESEED_LAT(LAT), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt         (gnt),
    .rnd_out     (rnd_out),
    .reseed_req  (reseed_req),
    .reseed_seed (reseed_seed),
    .reseed_ack  (reseed_ack),
    .busy        (busy),
    .rng_seed    (rng_seed),
    .rng_re_seed (rng_re_seed),
    .rng_rnd     (rng_rnd)
`ifdef RNG_SHARE_CTRL_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  // Generator stub
  logic [31:0] g_s  = 32'h0000_1000;
  logic [31:0] g_p1 = 32'h0;
  logic [31:0] g_p2 = 32'h0;
  always @(posedge clk) begin
    g_s  <= rng_re_seed ? rng_seed : g_s + 32'd1;
    g_p1 <= g_s;
    g_p2 <= g_p1;
  end
  assign rng_rnd = g_p2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: reseed tracked as an age timeline (0 = seed pulse,
  // 0..LAT busy, LAT+1 = ack cycle), grants chosen by the round-robin rule.
  typedef struct {
    int           ptr;
    int           age;
    logic [N-1:0] gnt;
    logic [31:0]  rnd;
    logic         ack;
    logic [31:0]  seed;
  } model_t;

  model_t m = '{ptr: 0, age: -1, gnt: '0, rnd: '0, ack: 1'b0, seed: '0};

  function automatic model_t model_next(model_t c, logic rst_i, logic [N-1:0] req_i,
                                        logic rs_i, logic [31:0] seed_i, logic [31:0] rnd_i);
    model_t n;
    bit     run;
    bit     found;
    int     i;
    n = c;
    if (rst_i) begin
      n.ptr = 0; n.age = -1; n.gnt = '0; n.rnd = '0; n.ack = 1'b0; n.seed = '0;
      return n;
    end
    run   = (c.age < 0) || (c.age > LAT);
    n.gnt = '0;
    if (run && rs_i) begin
      n.seed = seed_i;
      n.age  = 0;
    end else begin
      n.age = (c.age >= 0 && c.age <= LAT) ? c.age + 1 : -1;
      if (run) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          i = (c.ptr + k) % N;
          if (!found && req_i[i] && !c.gnt[i]) begin
            found    = 1'b1;
            n.gnt[i] = 1'b1;
            n.rnd    = rnd_i;
            n.ptr    = (i + 1) % N;
          end
        end
      end
    end
    n.ack = (n.age == LAT + 1);
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, req, reseed_req, reseed_seed, rng_rnd);

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mdl_gnt",    32'(gnt),         32'(m.gnt));
      chk("mdl_rnd",    rnd_out,          m.rnd);
      chk("mdl_ack",    32'(reseed_ack),  32'(m.ack));
      chk("mdl_busy",   32'(busy),        32'(m.age >= 0 && m.age <= LAT));
      chk("mdl_reseed", 32'(rng_re_seed), 32'(m.age == 0));
      chk("mdl_seed",   rng_seed,         m.seed);
    end
  end

  // Cycle vectors: inputs applied, then outputs expected after one edge.
  typedef struct {
    logic         rst;
    logic         rs;
    logic [31:0]  seed;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic         busy;
    logic         re;
    logic         ack;
    logic         crnd;
    logic [31:0]  rnd;
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  function automatic vec_t mk(logic r, logic s, logic [31:0] sd, logic [N-1:0] rq,
                              logic [N-1:0] g, logic b, logic re, logic a, logic cr, logic [31:0] rn);
    vec_t v;
    v.rst = r; v.rs = s; v.seed = sd; v.req = rq; v.gnt = g;
    v.busy = b; v.re = re; v.ack = a; v.crnd = cr; v.rnd = rn;
    return v;
  endfunction

  int          nbusy, npulse, nw;
  bit          got_ack;
  logic [31:0] prev, last;
  logic [N-1:0] rn;
  bit          seen [logic [31:0]];

  initial begin
    tv[0]  = mk(1, 0, 32'h0,        4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0);
    tv[1]  = mk(0, 1, 32'hDEADBEEF, 4'b0110, 4'b0000, 1, 1, 0, 0, 32'h0);
    tv[2]  = mk(0, 1, 32'hDEADBEEF, 4'b0110, 4'b0000, 1, 0, 0, 0, 32'h0);
    tv[3]  = mk(0, 1, 32'hDEADBEEF, 4'b0110, 4'b0000, 1, 0, 0, 0, 32'h0);
    tv[4]  = mk(0, 1, 32'hDEADBEEF, 4'b0110, 4'b0000, 0, 0, 1, 0, 32'h0);
    tv[5]  = mk(0, 0, 32'hDEADBEEF, 4'b0110, 4'b0010, 0, 0, 0, 1, 32'hDEADBEEF);
    tv[6]  = mk(0, 0, 32'hDEADBEEF, 4'b0100, 4'b0100, 0, 0, 0, 1, 32'hDEADBEF0);
    tv[7]  = mk(0, 0, 32'hDEADBEEF, 4'b0000, 4'b0000, 0, 0, 0, 1, 32'hDEADBEF0);
    tv[8]  = mk(0, 1, 32'h12345678, 4'b0000, 4'b0000, 1, 1, 0, 0, 32'h0);
    tv[9]  = mk(0, 1, 32'h12345678, 4'b0000, 4'b0000, 1, 0, 0, 0, 32'h0);
    tv[10] = mk(1, 0, 32'h12345678, 4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0);
    tv[11] = mk(0, 0, 32'h0,        4'b0001, 4'b0001, 0, 0, 0, 0, 32'h0);
    tv[12] = mk(0, 0, 32'h0,        4'b0000, 4'b0000, 0, 0, 0, 0, 32'h0);

    rst = 1'b1; req = '0; reseed_req = 1'b0; reseed_seed = '0;
    @(negedge clk);
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;

    chk("rst_gnt",    32'(gnt),         32'h0);
    chk("rst_rnd",    rnd_out,          32'h0);
    chk("rst_ack",    32'(reseed_ack),  32'h0);
    chk("rst_busy",   32'(busy),        32'h0);
    chk("rst_seed",   rng_seed,         32'h0);
    chk("rst_reseed", 32'(rng_re_seed), 32'h0);

    // Single requester held: masked every other cycle.
    req = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      prev = rng_rnd;
      tick();
      chk("single_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
      if (k % 2 == 0) begin
        chk("single_rnd", rnd_out, prev);
        if (k >= 2) chk("single_step", rnd_out - last, 32'd2);
        last = rnd_out;
      end
    end
    req = '0;
    tick();

    // All four held: strict rotation, one word per cycle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      prev = rng_rnd;
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      chk("rr_rnd", rnd_out, prev);
      if (k >= 1) chk("rr_step", rnd_out - last, 32'd1);
      last = rnd_out;
    end
    req = '0;
    tick();

    // Table: reseed with simultaneous requests, then rst during FLUSH.
    for (int r = 0; r < NV; r++) begin
      rst = tv[r].rst; reseed_req = tv[r].rs; reseed_seed = tv[r].seed; req = tv[r].req;
      tick();
      chk("tv_gnt",    32'(gnt),         32'(tv[r].gnt));
      chk("tv_busy",   32'(busy),        32'(tv[r].busy));
      chk("tv_reseed", 32'(rng_re_seed), 32'(tv[r].re));
      chk("tv_ack",    32'(reseed_ack),  32'(tv[r].ack));
      if (tv[r].crnd) chk("tv_rnd", rnd_out, tv[r].rnd);
    end
    rst = 1'b0; reseed_req = 1'b0; req = '0;
    tick();

    // Reseed then ten single-requester words from the new seed.
    reseed_req = 1'b1; reseed_seed = 32'hDEADBEEF; req = 4'b0001;
    nbusy = 0; npulse = 0; got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      tick();
      if (busy) nbusy++;
      if (rng_re_seed) begin
        npulse++;
        chk("rs_seed", rng_seed, 32'hDEADBEEF);
      end
      if (reseed_ack) got_ack = 1'b1;
    end
    reseed_req = 1'b0;
    chk("rs_ack_seen", 32'(got_ack), 32'd1);
    chk("rs_busy_len", 32'(nbusy),   32'(1 + LAT));
    chk("rs_pulses",   32'(npulse),  32'd1);
    nw = 0;
    for (int c = 0; c < 40 && nw < 10; c++) begin
      tick();
      if (gnt[0]) begin
        chk("rs_word", rnd_out, 32'hDEADBEEF + 32'(2 * nw));
        nw++;
      end
    end
    chk("rs_nwords", 32'(nw), 32'd10);
    req = '0;
    tick();

`ifdef RNG_SHARE_CTRL_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    repeat (6) tick();
    req = '0;
    chk("stat_cnt3", 32'(grant_cnt[15:0]), 32'd3);
    reseed_req = 1'b1; reseed_seed = 32'h0000_0042; got_ack = 1'b0;
    for (int c = 0; c < 20 && !got_ack; c++) begin
      tick();
      if (reseed_ack) got_ack = 1'b1;
    end
    reseed_req = 1'b0;
    chk("stat_ack_seen", 32'(got_ack), 32'd1);
    chk("stat_clr", 32'(grant_cnt[15:0]), 32'd0);
    tick();
`endif

    // Randomized protocol-following traffic with reseeds and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        reseed_req = 1'b0;
      end
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (req[i] && gnt[i])  rn[i] = 1'b0;
          else if (!req[i])      rn[i] = ($urandom_range(0, 2) == 0);
          else                   rn[i] = 1'b1;
        end
        req = rn;
        if (reseed_req && reseed_ack) begin
          reseed_req = 1'b0;
        end else if (!reseed_req && $urandom_range(0, 79) == 0) begin
          reseed_req  = 1'b1;
          reseed_seed = $urandom;
        end
      end
      tick();
      if (reseed_ack || rst) seen.delete();
      if (|gnt) begin
        chk("uniq_word", 32'(seen.exists(rnd_out)), 32'd0);
        seen[rnd_out] = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_share_ctrl.md
Name: rng_share_ctrl

Overview:
- Controller that shares one free-running 32-bit Tausworthe-113 generator between N requesters.
- Delivers each generated word to at most one requester.
- Sequences reseed operations: issues the seed pulse, then flushes stale words for the generator's reseed latency.
- Sits between the taus113 instance and consumer blocks (stochastic compute lanes).

Parameters:
- N_REQ, 4, number of requesters (2..16).
- RESEED_LAT, 2, cycles after the re_seed pulse before generator output reflects the new seed.
- CNT_W, 16, width of per-requester grant counters (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- req  in  N_REQ  level request per requester; held until granted.
- gnt  out  N_REQ  one-hot grant, single-cycle pulse.
- rnd_out  out  32  word delivered with gnt.
- reseed_req  in  1  reseed request; held until reseed_ack.
- reseed_seed  in  32  seed value; stable while reseed_req is high.
- reseed_ack  out  1  one-cycle pulse when reseed completes.
- busy  out  1  high when state is not RUN.
- rng_seed  out  32  to generator seed input.
- rng_re_seed  out  1  to generator re_seed input.
- rng_rnd  in  32  generator output; changes every cycle.

Behaviour:
- Reset values: gnt=0, rnd_out=0, reseed_ack=0, busy=0, rng_seed=0, rng_re_seed=0, RR pointer=0, state=RUN, flush counter=0.
- State RUN:
  - If reseed_req=1: latch reseed_seed into rng_seed, go to ISSUE. No grant this cycle; reseed has priority over req.
  - Else pick a requester by round-robin from eligible = req & ~gnt.
    - Masking the requester currently being granted prevents a double grant while its req falls.
    - Search starts at pointer; pointer <= winner+1 mod N_REQ.
  - Grant is registered: at the edge, gnt <= onehot(winner) and rnd_out <= rng_rnd.
  - Result: gnt and rnd_out are visible the next cycle (latency 1). rnd_out holds until the next grant.
  - Each generator word goes to at most one requester.
  - Requester rules:
    - Deassert req in the cycle gnt is high.
    - One requester gets at most one grant every 2 cycles.
    - Aggregate throughput is 1 word/cycle when 2 or more requesters are active.
- State ISSUE (1 cycle): rng_re_seed=1, rng_seed=latched seed, counter <= RESEED_LAT-1, go to FLUSH.
- State FLUSH:
  - rng_re_seed=0, no grants.
  - Count down; at 0, pulse reseed_ack for one cycle and return to RUN.
  - The first word granted after reseed_ack is the generator's first post-reseed output.
- reseed_req while busy: ignored until RUN. The requester keeps holding; it is then serviced in RUN (a second reseed).
- req while busy: stalls with no loss; grants resume the cycle after reseed_ack.
- rst mid-reseed: return to RUN immediately; rng_re_seed=0; no ack. The reseed is abandoned and the requester must re-request.
- gnt in the cycle of reseed_req acceptance: a grant registered the previous cycle still completes. No new grant is issued.

Optional Feature:
- Macro RNG_SHARE_CTRL_STATS_EN.
- When defined:
  - Adds output grant_cnt[N_REQ*CNT_W].
  - One saturating counter per requester, +1 per gnt, holds at all-ones.
  - Cleared by rst and by each reseed_ack, so statistics are per seed epoch.
- When undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package rng_share_pkg holds:
  - state enum {RUN, ISSUE, FLUSH};
  - RNG_W=32 constant;
  - default RESEED_LAT constant;
  - function onehot(idx).
- Sub-module rr_arbiter (N inputs, eligible mask, pointer update, one-hot winner), reusable by other shared RNG blocks.
- FSM, output registers and stats live in the top module.

Test Plan:
- Stub rng_rnd = free-running cycle counter; req=4'b0001 held -> gnt pulses every 2nd cycle. rnd_out equals counter value of the cycle before gnt. No repeated values.
- Stub counter; req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... Each rnd_out distinct, consecutive counter values.
- Real taus113, reseed_req with seed 0xDEADBEEF:
  - rng_re_seed pulses once with rng_seed=0xDEADBEEF;
  - busy high 1+RESEED_LAT cycles;
  - reseed_ack one cycle;
  - next 10 single-requester words match the golden Tausworthe-113 model from that seed, first = 0xB844A309.
- reseed_req and req=4'b0110 in the same cycle -> no grant until after reseed_ack. Then gnt 0010 then 0100.
- rst asserted during FLUSH -> next cycle busy=0, rng_re_seed=0, no reseed_ack. Grants resume on the following request.
- STATS_EN: requester 0 granted 3 times -> grant_cnt[15:0]=3. After reseed_ack -> 0. Preset near saturation -> holds at 0xFFFF.
